// File: rtl/rv_dmem_bridge.sv
`timescale 1ns/1ps
// uRV data-port to pipelined Wishbone bridge: one outstanding access, registered bus
// and core-side outputs, sticky error flag and a saturating timeout on the ack phase.
module rv_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_LOAD_DATA  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [31:0]       ldata_q, ldata_d;
    logic              ld_done_q, ld_done_d;
    logic              st_done_q, st_done_d;
    logic              berr_q, berr_d;
    logic              ready_q, ready_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;

    logic              idle_s, accept_s, timeout_hit_s, finish_s, fail_s;

    assign idle_s        = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept_s      = idle_s && (dm_load_i || dm_store_i);
    assign timeout_hit_s = TO_EN && (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
    // An access ends on ack/err at strobe acceptance, on ack/err in WAIT, or on timeout.
    assign finish_s      = ((state_q == ST_REQ) && !wb_stall_i && (wb_ack_i || wb_err_i)) ||
                           ((state_q == ST_WAIT) && (wb_ack_i || wb_err_i || timeout_hit_s));
    assign fail_s        = wb_err_i || (!wb_ack_i && timeout_hit_s);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (wb_stall_i) begin
                    state_d = ST_REQ;
                end else if (wb_ack_i || wb_err_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (finish_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        ldata_d   = ldata_q;
        ld_done_d = finish_s && !we_q;
        st_done_d = finish_s && we_q;
        berr_d    = berr_q;
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
        cyc_d     = (state_d == ST_REQ) || (state_d == ST_WAIT);
        stb_d     = (state_d == ST_REQ);

        if (accept_s) begin
            adr_d = dm_addr_i;
            we_d  = dm_store_i;
            if (dm_store_i) begin
                sel_d = dm_data_select_i;
                dat_d = dm_data_s_i;
            end else begin
                sel_d = 4'hF;
            end
        end else begin
            adr_d = adr_q;
        end

        if (state_q == ST_REQ) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (state_q == ST_WAIT) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (finish_s && !we_q) begin
            ldata_d = fail_s ? ERR_LOAD_DATA : wb_dat_i;
        end else begin
            ldata_d = ldata_q;
        end

        // A simultaneous load+store is a core protocol error: the store wins.
        if ((finish_s && fail_s) || (accept_s && dm_load_i && dm_store_i)) begin
            berr_d = 1'b1;
        end else begin
            berr_d = berr_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            ldata_q   <= 32'h0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            berr_q    <= 1'b0;
            ready_q   <= 1'b1;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            ldata_q   <= ldata_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
            berr_q    <= berr_d;
            ready_q   <= ready_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
        end
    end

    assign dm_ready_o      = ready_q;
    assign dm_data_l_o     = ldata_q;
    assign dm_load_done_o  = ld_done_q;
    assign dm_store_done_o = st_done_q;
    assign bus_err_o       = berr_q;
    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = stb_q;
    assign wb_we_o         = we_q;
    assign wb_adr_o        = adr_q;
    assign wb_sel_o        = sel_q;
    assign wb_dat_o        = dat_q;

endmodule

// File: tb/tb_rv_dmem_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for rv_dmem_bridge: a planned Wishbone slave, a word-array reference
// memory, and a monitor that checks every completion pulse against queued expectations.
module tb_rv_dmem_bridge;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] dm_addr_i, dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i, dm_store_i;
    logic        dm_ready_o, dm_load_done_o, dm_store_done_o, bus_err_o;
    logic [31:0] dm_data_l_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i, wb_stall_i;

    rv_dmem_bridge #(.TIMEOUT_CYCLES(TO), .ERR_LOAD_DATA(ERR)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
        .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_ready_o(dm_ready_o),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o), .bus_err_o(bus_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int stall; int delay; bit err; bit noack; } plan_t;
    typedef struct { bit is_load; logic [31:0] data; bit berr; } exp_t;

    plan_t       plan_q[$];
    exp_t        sb_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] slv_mem[16];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_berr = 1'b0;
    bit          late_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Wishbone slave: follows one plan per accepted strobe
    initial begin : slave
        plan_t p;
        int    idx;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        forever begin
            @(negedge clk_i);
            wb_ack_i = late_ack; wb_err_i = 1'b0; wb_stall_i = 1'b0;
            if (rst_n_i && wb_cyc_o && wb_stb_o && plan_q.size() > 0) begin
                p   = plan_q.pop_front();
                idx = int'(wb_adr_o[5:2]);
                repeat (p.stall) begin
                    wb_stall_i = 1'b1;
                    @(negedge clk_i);
                end
                wb_stall_i = 1'b0;
                if (!p.noack) begin
                    repeat (p.delay) @(negedge clk_i);
                    if (p.err) begin
                        wb_err_i = 1'b1;
                    end else begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o)
                            slv_mem[idx] = (slv_mem[idx] & ~bmask(wb_sel_o)) | (wb_dat_o & bmask(wb_sel_o));
                        else
                            wb_dat_i = slv_mem[idx];
                    end
                end
            end
        end
    end

    // Monitor: pop one expectation per completion pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (dm_load_done_o || dm_store_done_o) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got load=%b store=%b expected no pulse at %0t",
                             dm_load_done_o, dm_store_done_o, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_kind", {30'b0, dm_load_done_o, dm_store_done_o},
                        e.is_load ? 32'd2 : 32'd1);
                    if (e.is_load) chk("load_data", dm_data_l_o, e.data);
                    chk("bus_err_at_done", {31'b0, bus_err_o}, {31'b0, e.berr});
                end
            end
        end
    end

    task automatic issue(input bit ld, input bit st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel, input plan_t p);
        int   w;
        int   idx;
        exp_t e;
        w = 0;
        while (!dm_ready_o && w < 60) begin
            @(negedge clk_i);
            w++;
        end
        if (!dm_ready_o) begin
            n_cmp++; n_err++;
            $display("FAIL ready_wait: got dm_ready_o=0 expected 1 within 60 cycles");
            return;
        end
        idx = int'(addr[5:2]);
        plan_q.push_back(p);
        if ((ld && st) || p.err || p.noack) exp_berr = 1'b1;
        e.is_load = !st;
        e.berr    = exp_berr;
        e.data    = 32'h0;
        if (!st) begin
            e.data = (p.err || p.noack) ? ERR : ref_mem[idx];
        end else if (!p.err && !p.noack) begin
            ref_mem[idx] = (ref_mem[idx] & ~bmask(sel)) | (data & bmask(sel));
        end
        sb_q.push_back(e);
        dm_addr_i = addr; dm_data_s_i = data; dm_data_select_i = sel;
        dm_load_i = ld; dm_store_i = st;
        @(negedge clk_i);
        dm_load_i = 1'b0; dm_store_i = 1'b0;
    endtask

    task automatic rand_access(input bit allow_err);
        plan_t       p;
        int          idx;
        bit          st;
        logic [31:0] addr;
        idx     = $urandom_range(0, 15);
        st      = 1'($urandom_range(0, 1));
        p.stall = $urandom_range(0, 3);
        p.delay = $urandom_range(0, 4);
        p.err   = allow_err && ($urandom_range(0, 7) == 0);
        p.noack = allow_err && !p.err && ($urandom_range(0, 15) == 0);
        addr    = 32'h100 + 32'(idx) * 32'd4;
        issue(!st, st, addr, $urandom, 4'($urandom_range(0, 15)), p);
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 300) begin
            @(negedge clk_i);
            w++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : main
        plan_t p0, p;
        int    cnt, viol;
        bit    seen;
        dm_addr_i = 32'h0; dm_data_s_i = 32'h0; dm_data_select_i = 4'h0;
        dm_load_i = 1'b0; dm_store_i = 1'b0; rst_n_i = 1'b0;
        p0 = '{0, 0, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[0] = 32'hCAFEBABE;
        slv_mem[0] = 32'hCAFEBABE;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", {31'b0, dm_ready_o}, 32'd1);
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wb_we_o}, 32'd0);
        chk("rst_berr", {31'b0, bus_err_o}, 32'd0);
        chk("rst_done", {30'b0, dm_load_done_o, dm_store_done_o}, 32'd0);
        chk("rst_data_l", dm_data_l_o, 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_sel", {28'b0, wb_sel_o}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Zero-wait load
        issue(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, p0);
        chk("t1_stb", {31'b0, wb_stb_o}, 32'd1);
        chk("t1_sel", {28'b0, wb_sel_o}, 32'hF);
        chk("t1_adr", wb_adr_o, 32'h100);
        chk("t1_ready_low", {31'b0, dm_ready_o}, 32'd0);
        @(negedge clk_i);
        chk("t1_done_latency", {31'b0, dm_load_done_o}, 32'd1);
        chk("t1_data", dm_data_l_o, 32'hCAFEBABE);
        @(negedge clk_i);
        chk("t1_pulse_width", {31'b0, dm_load_done_o}, 32'd0);
        chk("t1_data_held", dm_data_l_o, 32'hCAFEBABE);

        // Stalled store with delayed ack
        p = '{3, 2, 1'b0, 1'b0};
        issue(1'b0, 1'b1, 32'h104, 32'h12345678, 4'b0011, p);
        cnt = 0; viol = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (wb_stb_o) begin
                cnt++;
                chk("t2_dat_stable", wb_dat_o, 32'h12345678);
                chk("t2_sel_stable", {28'b0, wb_sel_o}, 32'h3);
            end
            if (dm_store_done_o) seen = 1'b1;
            else begin
                if (dm_ready_o) viol++;
                @(negedge clk_i);
            end
        end
        chk("t2_stb_cycles", 32'(cnt), 32'd4);
        chk("t2_ready_low", 32'(viol), 32'd0);
        chk("t2_done_seen", {31'b0, seen}, 32'd1);

        // Back-to-back: store accepted in the load's done cycle
        issue(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, p0);
        @(negedge clk_i);
        chk("t4_load_done", {31'b0, dm_load_done_o}, 32'd1);
        chk("t4_ready_in_done", {31'b0, dm_ready_o}, 32'd1);
        issue(1'b0, 1'b1, 32'h10C, 32'hA5A55A5A, 4'hF, p0);
        chk("t4_stb_no_gap", {31'b0, wb_stb_o}, 32'd1);
        chk("t4_we", {31'b0, wb_we_o}, 32'd1);
        @(negedge clk_i);
        chk("t4_store_done", {31'b0, dm_store_done_o}, 32'd1);

        for (int i = 0; i < 40; i++) rand_access(1'b0);
        drain();

        // Timeout on a load with no ack
        p = '{0, 0, 1'b0, 1'b1};
        issue(1'b1, 1'b0, 32'h110, 32'h0, 4'h0, p);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (dm_load_done_o) seen = 1'b1;
            else begin
                if (wb_cyc_o && !wb_stb_o) cnt++;
                @(negedge clk_i);
            end
        end
        chk("t3_wait_cycles", 32'(cnt), 32'd8);
        chk("t3_cyc_dropped", {31'b0, wb_cyc_o}, 32'd0);
        chk("t3_data", dm_data_l_o, ERR);
        chk("t3_berr", {31'b0, bus_err_o}, 32'd1);

        // Load and store together
        issue(1'b1, 1'b1, 32'h114, 32'h0BADF00D, 4'hF, p0);
        chk("t5_we", {31'b0, wb_we_o}, 32'd1);
        @(negedge clk_i);
        chk("t5_done", {30'b0, dm_load_done_o, dm_store_done_o}, 32'd1);
        chk("t5_berr", {31'b0, bus_err_o}, 32'd1);

        for (int i = 0; i < 40; i++) rand_access(1'b1);
        drain();

        // Asynchronous reset during WAIT, then a stray ack
        p = '{0, 0, 1'b0, 1'b1};
        issue(1'b1, 1'b0, 32'h118, 32'h0, 4'h0, p);
        repeat (3) @(negedge clk_i);
        chk("t6_cyc_before", {31'b0, wb_cyc_o}, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t6_cyc_async", {31'b0, wb_cyc_o}, 32'd0);
        chk("t6_stb_async", {31'b0, wb_stb_o}, 32'd0);
        chk("t6_ready_async", {31'b0, dm_ready_o}, 32'd1);
        sb_q.delete();
        plan_q.delete();
        exp_berr = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #2 late_ack = 1'b1;
        @(posedge clk_i); #2 late_ack = 1'b0;
        @(negedge clk_i);
        chk("t6_ready_after", {31'b0, dm_ready_o}, 32'd1);
        chk("t6_cyc_after", {31'b0, wb_cyc_o}, 32'd0);
        chk("t6_berr_cleared", {31'b0, bus_err_o}, 32'd0);

        issue(1'b0, 1'b1, 32'h11C, 32'h600DCAFE, 4'hF, p0);
        issue(1'b1, 1'b0, 32'h11C, 32'h0, 4'h0, p0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
